// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data-memory responder.
//   mem_size_e    - access size encoding carried on i_data_rd_en_ctrl
//   dmem_state_e  - responder FSM states (CLEAR sweep, READY)
//   is_misaligned - flags accesses that must be suppressed and reported
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } mem_size_e;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } dmem_state_e;

    // Illegal size counts as misaligned so one flag covers both faults.
    function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: data bus between the memory-access stage (master) and
// the data-memory responder (slave).
//   i_data_addr/i_data_wr/i_data_rd_en_ctrl/i_data_rd_en/i_data_wr_en - request
//   i_err_clr                                                          - clears o_misaligned
//   o_data_rd/o_busy/o_misaligned                                      - response/status
// Optional (macro DMEM_STATS_EN): o_load_cnt, o_store_cnt access counters.
interface dmem_responder_if;

    logic [31:0] i_data_addr;
    logic [31:0] i_data_wr;
    logic [1:0]  i_data_rd_en_ctrl;
    logic        i_data_rd_en;
    logic        i_data_wr_en;
    logic        i_err_clr;
    logic [31:0] o_data_rd;
    logic        o_busy;
    logic        o_misaligned;
`ifdef DMEM_STATS_EN
    logic [31:0] o_load_cnt;
    logic [31:0] o_store_cnt;

    modport master (
        output i_data_addr, i_data_wr, i_data_rd_en_ctrl, i_data_rd_en, i_data_wr_en, i_err_clr,
        input  o_data_rd, o_busy, o_misaligned, o_load_cnt, o_store_cnt
    );
    modport slave (
        input  i_data_addr, i_data_wr, i_data_rd_en_ctrl, i_data_rd_en, i_data_wr_en, i_err_clr,
        output o_data_rd, o_busy, o_misaligned, o_load_cnt, o_store_cnt
    );
`else
    modport master (
        output i_data_addr, i_data_wr, i_data_rd_en_ctrl, i_data_rd_en, i_data_wr_en, i_err_clr,
        input  o_data_rd, o_busy, o_misaligned
    );
    modport slave (
        input  i_data_addr, i_data_wr, i_data_rd_en_ctrl, i_data_rd_en, i_data_wr_en, i_err_clr,
        output o_data_rd, o_busy, o_misaligned
    );
`endif

endinterface

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational byte-lane steering for the data memory.
//   size, addr_lo  - access size and low address bits
//   wdata          - right-aligned store data
//   rword          - full 32-bit word read from the array
//   be, wdata_rep  - byte enables and lane-replicated store data
//   rdata          - right-aligned, zero-filled load data
// Alignment is not checked here; the caller gates misaligned accesses.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  mem_size_e   size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata
);

    logic [31:0] rshift;

    always_comb begin
        be        = '0;
        wdata_rep = '0;
        rdata     = '0;
        rshift    = rword >> {addr_lo, 3'b000};
        case (size)
            SZ_BYTE: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata     = {24'h0, rshift[7:0]};
            end
            SZ_HALF: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                rdata     = {16'h0, addr_lo[1] ? rword[31:16] : rword[15:0]};
            end
            SZ_WORD: begin
                be        = 4'b1111;
                wdata_rep = wdata;
                rdata     = rword;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: byte-addressed, word-organised data memory for the RV32I
// memory-access stage. Combinational loads, edge-written stores with byte
// enables, optional post-reset clear sweep, sticky misalignment flag.
//   clk, rst_n (sync, active-low), clk_en (freezes all state when low)
//   bus - dmem_responder_if.slave (request, load data, busy, misaligned)
// Parameters: DEPTH (words, power of two >= 4), INIT_CLEAR (1 = zero sweep).
// Macro DMEM_STATS_EN adds o_load_cnt / o_store_cnt on the interface.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH      = 1024,
    parameter bit          INIT_CLEAR = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_en,
    dmem_responder_if.slave  bus
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [31:0] mem [DEPTH];

    dmem_state_e state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          mis_q, mis_d;

    mem_size_e     size;
    logic [1:0]    addr_lo;
    logic [AW-1:0] widx;
    logic          misal, ready, ld_ok, st_ok;
    logic [3:0]    be;
    logic [31:0]   wdata_rep, rdata_al, rword;

    logic          mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_idx;
    logic [31:0]   mem_wdata;

    // Address bits above the array wrap and are intentionally ignored.
    logic unused_addr_hi;
    assign unused_addr_hi = ^{bus.i_data_addr[31:AW+2]};

    assign size    = mem_size_e'(bus.i_data_rd_en_ctrl);
    assign addr_lo = bus.i_data_addr[1:0];
    assign widx    = bus.i_data_addr[AW+1:2];
    assign rword   = mem[widx];

    dmem_lane_align u_align (
        .size      (size),
        .addr_lo   (addr_lo),
        .wdata     (bus.i_data_wr),
        .rword     (rword),
        .be        (be),
        .wdata_rep (wdata_rep),
        .rdata     (rdata_al)
    );

    always_comb begin
        misal         = is_misaligned(size, addr_lo);
        ready         = (state_q == READY);
        ld_ok         = ready && bus.i_data_rd_en && !misal;
        st_ok         = ready && bus.i_data_wr_en && !misal;
        bus.o_data_rd = ld_ok ? rdata_al : '0;
        bus.o_busy    = (state_q == CLEAR);
        bus.o_misaligned = mis_q;
    end

    // Single write port shared by the clear sweep and accepted stores.
    always_comb begin
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_idx   = widx;
        mem_wdata = wdata_rep;
        if (state_q == CLEAR) begin
            mem_we    = 1'b1;
            mem_be    = 4'b1111;
            mem_idx   = idx_q;
            mem_wdata = '0;
        end else if (st_ok) begin
            mem_we = 1'b1;
            mem_be = be;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && clk_en && mem_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (mem_be[i]) mem[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mis_d   = mis_q;
        if (state_q == CLEAR) begin
            idx_d = idx_q + 1'b1;
            if (idx_q == AW'(DEPTH - 1)) state_d = READY;
        end
        if (bus.i_err_clr) mis_d = 1'b0;
        // Set after clear so a new fault wins over a same-cycle clear.
        if (ready && (bus.i_data_rd_en || bus.i_data_wr_en) && misal) mis_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= INIT_CLEAR ? CLEAR : READY;
            idx_q   <= '0;
            mis_q   <= 1'b0;
        end else if (clk_en) begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mis_q   <= mis_d;
        end
    end

`ifdef DMEM_STATS_EN
    logic [31:0] ld_cnt_q, ld_cnt_d, st_cnt_q, st_cnt_d;

    always_comb begin
        ld_cnt_d = ld_cnt_q + (ld_ok ? 32'd1 : 32'd0);
        st_cnt_d = st_cnt_q + (st_ok ? 32'd1 : 32'd0);
        bus.o_load_cnt  = ld_cnt_q;
        bus.o_store_cnt = st_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ld_cnt_q <= '0;
            st_cnt_q <= '0;
        end else if (clk_en) begin
            ld_cnt_q <= ld_cnt_d;
            st_cnt_q <= st_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder with
// DEPTH=16, INIT_CLEAR=1. Counter checks are compiled in with DMEM_STATS_EN.
module tb_dmem_responder;
    import dmem_pkg::*;

    logic clk;
    logic rst_n;
    logic clk_en;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    dmem_responder_if bus ();

    dmem_responder #(.DEPTH(16), .INIT_CLEAR(1'b1)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .clk_en (clk_en),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.i_data_rd_en = 1'b0;
        bus.i_data_wr_en = 1'b0;
        bus.i_err_clr    = 1'b0;
    endtask

    // Request held across exactly one rising edge.
    task automatic access(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                          input logic rd, input logic wr);
        bus.i_data_addr       = a;
        bus.i_data_wr         = d;
        bus.i_data_rd_en_ctrl = sz;
        bus.i_data_rd_en      = rd;
        bus.i_data_wr_en      = wr;
        tick();
        idle();
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        access(a, d, sz, 1'b0, 1'b1);
    endtask

    // Combinational load check; rd_en is dropped before the edge.
    task automatic load_chk(input string tag, input logic [31:0] a, input logic [1:0] sz,
                            input logic [31:0] exp);
        bus.i_data_addr       = a;
        bus.i_data_rd_en_ctrl = sz;
        bus.i_data_rd_en      = 1'b1;
        #1;
        check(tag, bus.o_data_rd, exp);
        bus.i_data_rd_en = 1'b0;
        tick();
    endtask

    task automatic wait_ready(input string tag, input int unsigned exp);
        int unsigned cnt = 0;
        while (bus.o_busy === 1'b1 && cnt < 200) begin
            tick();
            cnt++;
        end
        check(tag, cnt, exp);
    endtask

    initial begin
        rst_n  = 1'b0;
        clk_en = 1'b1;
        bus.i_data_addr       = '0;
        bus.i_data_wr         = '0;
        bus.i_data_rd_en_ctrl = 2'b10;
        idle();
        tick();
        tick();

        // Reset state
        check("rst_busy", {31'h0, bus.o_busy}, 32'h1);
        check("rst_mis", {31'h0, bus.o_misaligned}, 32'h0);
        load_chk("rst_rdata", 32'h0, 2'b10, 32'h0);

        // Sweep with a store held throughout: must be dropped
        bus.i_data_addr       = 32'h10;
        bus.i_data_wr         = 32'hDEADBEEF;
        bus.i_data_rd_en_ctrl = 2'b10;
        bus.i_data_wr_en      = 1'b1;
        rst_n = 1'b1;
        wait_ready("sweep_len", 16);
        idle();
        check("sweep_mis", {31'h0, bus.o_misaligned}, 32'h0);
        load_chk("busy_store_drop", 32'h10, 2'b10, 32'h0);
        load_chk("clear_w0", 32'h0, 2'b10, 32'h0);

        // Loads of each size
        store(32'h10, 32'hCAFEBABE, 2'b10);
        load_chk("lb_11", 32'h11, 2'b00, 32'h000000BA);
        load_chk("lb_13", 32'h13, 2'b00, 32'h000000CA);
        load_chk("lh_12", 32'h12, 2'b01, 32'h0000CAFE);
        load_chk("lh_10", 32'h10, 2'b01, 32'h0000BABE);
        load_chk("lw_10", 32'h10, 2'b10, 32'hCAFEBABE);
        #1;
        check("rd_en_low", bus.o_data_rd, 32'h0);

        // Partial stores preserve other lanes
        store(32'h20, 32'h12345678, 2'b10);
        store(32'h23, 32'hFFFFFFAB, 2'b00);
        load_chk("sb_23", 32'h20, 2'b10, 32'hAB345678);
        store(32'h20, 32'h77778000, 2'b01);
        load_chk("sh_20", 32'h20, 2'b10, 32'hAB348000);

        // Misaligned / illegal
        check("mis_pre", {31'h0, bus.o_misaligned}, 32'h0);
        store(32'h21, 32'h0000FFFF, 2'b01);
        check("mis_sh", {31'h0, bus.o_misaligned}, 32'h1);
        load_chk("sh_mis_mem", 32'h20, 2'b10, 32'hAB348000);
        bus.i_err_clr = 1'b1;
        tick();
        idle();
        check("mis_clr", {31'h0, bus.o_misaligned}, 32'h0);
        store(32'h22, 32'hFFFFFFFF, 2'b10);
        check("mis_sw", {31'h0, bus.o_misaligned}, 32'h1);
        load_chk("sw_mis_mem", 32'h20, 2'b10, 32'hAB348000);
        bus.i_err_clr = 1'b1;
        store(32'h20, 32'h00000000, 2'b11);
        check("mis_set_clr", {31'h0, bus.o_misaligned}, 32'h1);
        load_chk("ill_mem", 32'h20, 2'b10, 32'hAB348000);
        bus.i_err_clr = 1'b1;
        tick();
        idle();
        check("mis_clr2", {31'h0, bus.o_misaligned}, 32'h0);
        bus.i_data_addr       = 32'h21;
        bus.i_data_rd_en_ctrl = 2'b01;
        bus.i_data_rd_en      = 1'b1;
        #1;
        check("lh_mis_data", bus.o_data_rd, 32'h0);
        tick();
        idle();
        check("mis_ld", {31'h0, bus.o_misaligned}, 32'h1);
        load_chk("ill_ld_data", 32'h20, 2'b11, 32'h0);
        bus.i_err_clr = 1'b1;
        tick();
        idle();

        // Same-cycle load+store to one word
        bus.i_data_addr       = 32'h30;
        bus.i_data_wr         = 32'h55AA55AA;
        bus.i_data_rd_en_ctrl = 2'b10;
        bus.i_data_rd_en      = 1'b1;
        bus.i_data_wr_en      = 1'b1;
        #1;
        check("rw_old", bus.o_data_rd, 32'h0);
        tick();
        bus.i_data_wr_en = 1'b0;
        check("rw_new", bus.o_data_rd, 32'h55AA55AA);
        idle();
        tick();

        // clk_en low freezes writes and flags
        clk_en = 1'b0;
        store(32'h30, 32'h11111111, 2'b10);
        store(32'h31, 32'h0000FFFF, 2'b01);
        clk_en = 1'b1;
        check("cken_mis", {31'h0, bus.o_misaligned}, 32'h0);
        load_chk("cken_store", 32'h30, 2'b10, 32'h55AA55AA);

        // Reset mid-sweep restarts at index 0
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (7) tick();
        check("mid_busy", {31'h0, bus.o_busy}, 32'h1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        clk_en = 1'b0;
        repeat (3) tick();
        check("frozen_busy", {31'h0, bus.o_busy}, 32'h1);
        clk_en = 1'b1;
        wait_ready("resweep_len", 16);
        load_chk("resweep_clr", 32'h30, 2'b10, 32'h0);

`ifdef DMEM_STATS_EN
        check("ld_cnt_rst", bus.o_load_cnt, 32'd0);
        check("st_cnt_rst", bus.o_store_cnt, 32'd0);
        access(32'h30, 32'h0, 2'b10, 1'b1, 1'b0);          // load
        access(32'h34, 32'h1, 2'b10, 1'b0, 1'b1);          // store
        access(32'h34, 32'h0, 2'b00, 1'b1, 1'b0);          // load
        access(32'h31, 32'h0, 2'b01, 1'b1, 1'b0);          // misaligned load
        access(32'h32, 32'h0, 2'b10, 1'b0, 1'b1);          // misaligned store
        access(32'h38, 32'h5, 2'b10, 1'b1, 1'b1);          // load + store
        clk_en = 1'b0;
        access(32'h38, 32'h6, 2'b10, 1'b1, 1'b1);          // frozen
        clk_en = 1'b1;
        check("ld_cnt", bus.o_load_cnt, 32'd3);
        check("st_cnt", bus.o_store_cnt, 32'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
